// File: rtl/writeback_regfile.sv
// Writeback stage: result select, 31x32 register file with r0 hardwired to 0, and retire counter.
// Optional same-cycle write-to-read bypass when REGFILE_BYPASS_EN is defined.
module writeback_regfile #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               regwriteW,
  input  logic               memtoregW,
  input  logic [31:0]        rdW,
  input  logic [31:0]        aluoutW,
  input  logic [4:0]         writeregW,
  input  logic [4:0]         a1,
  input  logic [4:0]         a2,
  output logic [31:0]        rd1,
  output logic [31:0]        rd2,
  output logic [31:0]        resultW,
  output logic [COUNT_W-1:0] wbcount
);

  logic [31:0]        regs_q [31:1];
  logic [COUNT_W-1:0] wbcount_q;
  logic [COUNT_W-1:0] wbcount_d;
  logic               wr_en;

  assign resultW   = memtoregW ? rdW : aluoutW;
  // Writes to r0 are dropped entirely, including the retire count.
  assign wr_en     = regwriteW && (writeregW != 5'd0);
  assign wbcount_d = wbcount_q + COUNT_W'(1);
  assign wbcount   = wbcount_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      wbcount_q <= '0;
    end else if (wr_en) begin
      regs_q[writeregW] <= resultW;
      wbcount_q         <= wbcount_d;
    end
  end

  always_comb begin
    rd1 = '0;
    if (a1 != 5'd0) begin
      rd1 = regs_q[a1];
`ifdef REGFILE_BYPASS_EN
      if (rst_n && wr_en && (a1 == writeregW)) begin
        rd1 = resultW;
      end
`endif
    end
  end

  always_comb begin
    rd2 = '0;
    if (a2 != 5'd0) begin
      rd2 = regs_q[a2];
`ifdef REGFILE_BYPASS_EN
      if (rst_n && wr_en && (a2 == writeregW)) begin
        rd2 = resultW;
      end
`endif
    end
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile with a reference register model and expected-value queue.
// A second instance with COUNT_W=4 shares all stimulus to exercise counter wrap.
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        regwriteW;
  logic        memtoregW;
  logic [31:0] rdW;
  logic [31:0] aluoutW;
  logic [4:0]  writeregW;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic [31:0] rd1, rd2, resultW;
  logic [31:0] wbcount;
  logic [31:0] rd1_4, rd2_4, resultW_4;
  logic [3:0]  wbcount_4;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [32];
  int unsigned cnt;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  writeback_regfile dut (
    .clk(clk), .rst_n(rst_n), .regwriteW(regwriteW), .memtoregW(memtoregW),
    .rdW(rdW), .aluoutW(aluoutW), .writeregW(writeregW), .a1(a1), .a2(a2),
    .rd1(rd1), .rd2(rd2), .resultW(resultW), .wbcount(wbcount)
  );

  writeback_regfile #(.COUNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .regwriteW(regwriteW), .memtoregW(memtoregW),
    .rdW(rdW), .aluoutW(aluoutW), .writeregW(writeregW), .a1(a1), .a2(a2),
    .rd1(rd1_4), .rd2(rd2_4), .resultW(resultW_4), .wbcount(wbcount_4)
  );

  function automatic logic [31:0] exp_result();
    return memtoregW ? rdW : aluoutW;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'd0 : model[a];
`ifdef REGFILE_BYPASS_EN
    if (rst_n && regwriteW && (writeregW != 5'd0) && (a != 5'd0) && (a == writeregW))
      v = exp_result();
`endif
    return v;
  endfunction

  task automatic push(input logic [31:0] v);
    sb.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic chk_reads(input string tag);
    push(exp_rd(a1)); chk({tag, "_rd1"}, rd1);
    push(exp_rd(a2)); chk({tag, "_rd2"}, rd2);
  endtask

  task automatic chk_counts(input string tag);
    push(cnt);              chk({tag, "_wbcount"}, wbcount);
    push(cnt & 32'hF);      chk({tag, "_wbcount4"}, {28'd0, wbcount_4});
  endtask

  task automatic tick();
    if (rst_n && regwriteW && (writeregW != 5'd0)) begin
      model[writeregW] = exp_result();
      cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic m2r, input logic [31:0] rdv,
                       input logic [31:0] alu, input logic [4:0] wr);
    regwriteW = rw; memtoregW = m2r; rdW = rdv; aluoutW = alu; writeregW = wr;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    cnt = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    cnt = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    a1 = 5'd5; a2 = 5'd31;
    #2;
    chk_reads("reset_init");
    chk_counts("reset_init");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // First write accepted on the first edge after release; then async reset mid-cycle.
    drive(1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 5'd5);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    a1 = 5'd5; #1;
    push(32'hDEADBEEF); chk("r5_written", rd1);
    chk_counts("r5_written");
    assert_reset();
    #1;
    push(32'd0); chk("r5_async_clear", rd1);
    chk_counts("async_clear");

    // During reset: result select still live, bypass suppressed, write lost.
    drive(1'b1, 1'b1, 32'hCAFE0001, 32'h12345678, 5'd3);
    a1 = 5'd3; a2 = 5'd3; #1;
    push(32'hCAFE0001); chk("reset_resultW", resultW);
    push(32'd0); chk("reset_no_bypass", rd1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    rst_n = 1'b1; #1;
    push(32'd0); chk("reset_write_lost", rd1);
    chk_counts("reset_write_lost");

    // Result select: load data wins when memtoregW=1.
    drive(1'b1, 1'b1, 32'h11112222, 32'h33334444, 5'd7);
    a1 = 5'd0; a2 = 5'd7; #1;
    push(32'h11112222); chk("sel_load", resultW);
    push(32'h11112222); chk("sel_load_dut4", resultW_4);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0); #1;
    push(32'h11112222); chk("r7_read", rd2);
    chk_counts("r7_write");
    drive(1'b0, 1'b0, 32'h55556666, 32'h77778888, 5'd0); #1;
    push(32'h77778888); chk("sel_alu", resultW);

    // r0 write is discarded.
    drive(1'b1, 1'b0, 32'h0, 32'hFFFFFFFF, 5'd0);
    a1 = 5'd0; a2 = 5'd0;
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0); #1;
    push(32'd0); chk("r0_read", rd1);
    chk_counts("r0_write");

    // Same-cycle read of a register being written.
    drive(1'b1, 1'b0, 32'h0, 32'h1, 5'd9);
    tick();
    drive(1'b1, 1'b0, 32'h0, 32'h2, 5'd9);
    a1 = 5'd9; a2 = 5'd9; #1;
`ifdef REGFILE_BYPASS_EN
    push(32'h2); chk("same_cycle_rd1", rd1);
    push(32'h2); chk("same_cycle_rd2", rd2);
`else
    push(32'h1); chk("same_cycle_rd1", rd1);
    push(32'h1); chk("same_cycle_rd2", rd2);
`endif
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0); #1;
    push(32'h2); chk("next_cycle_rd1", rd1);
    push(32'h2); chk("next_cycle_rd2", rd2);
    chk_counts("same_cycle");

    // Populate a few registers, then 100 disabled cycles with random traffic.
    for (int i = 1; i < 32; i += 3) begin
      drive(1'b1, i[0], $urandom, $urandom, 5'(i));
      tick();
    end
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, 1'($urandom), $urandom, $urandom, 5'($urandom));
      a1 = 5'($urandom); a2 = 5'($urandom); #1;
      chk_reads("disabled");
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      a1 = 5'(i); a2 = 5'(31 - i); #1;
      chk_reads("sweep");
      push(exp_rd(a1)); chk("sweep_dut4", rd1_4);
    end
    chk_counts("disabled");

    // Counter wrap on the 4-bit instance: 1..15 then 0.
    @(negedge clk);
    assert_reset();
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 1'b0, 32'h0, 32'(i), 5'd1);
      tick();
      push(32'(i % 16)); chk("wrap4", {28'd0, wbcount_4});
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    a1 = 5'd1; a2 = 5'd2; #1;
    chk_reads("wrap_end");
    chk_counts("wrap_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
